seven_segment_scan_controller: RTL
==================================

Name: seven_segment_scan_controller

Overview:
Time-multiplexed scan and page controller for the 4-digit light-meter display. It drives one shared active-low segment bus and four active-low digit enables. It inserts a blanking gap between digits to suppress ghosting. It also sequences the decoder's 2-bit page select (ISO, shutter, focal, brightness) from a next-page button pulse or an auto-cycle timer. It sits between the seven-segment decoder outputs and the board display pins.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot; legal when >=4.
BLANK_CYCLES, 500, cycles at the start of each slot during which all digits are off; legal when 1 <= BLANK_CYCLES < CLK_DIV.
AUTO_FRAMES, 2000, frames per page in auto mode; legal when >=1.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  synchronous reset, active-high.
seg_in_1  in  8  decoder pattern, rightmost digit; active-low, bit7 = dp.
seg_in_2  in  8  decoder pattern, digit 2.
seg_in_3  in  8  decoder pattern, digit 3.
seg_in_4  in  8  decoder pattern, leftmost digit.
next_page  in  1  one-cycle pulse from the debounced button.
auto_en  in  1  level; enables auto page cycling.
select_out  out  2  page select to the decoder (00 ISO, 01 shutter, 10 focal, 11 brightness).
seg_out  out  8  shared segment bus, active-low.
an_out  out  4  digit enables, active-low; an_out[0] = digit 1.
frame_tick  out  1  one-cycle pulse once per full 4-digit scan.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. rst has priority over all other activity.
- Reset values: presc=0, idx=0, select_out=00, shadow regs=8'hFF, seg_out=8'hFF, an_out=4'b1111, frame_tick=0, pending=0, auto_cnt=0.
- Counters:
  - presc counts 0..CLK_DIV-1 and wraps.
  - On wrap, idx increments 0..3 and wraps 3->0.
  - A frame is 4*CLK_DIV cycles.
- Frame start (FS) is any cycle with idx==0 and presc==0, including the first cycle after reset release.
- At FS:
  - shadow_k <= seg_in_k for k=1..4.
  - frame_tick=1 on the next cycle only.
  - If advance, select_out <= select_out+1 (mod 4, 11 wraps to 00), and pending <= 0.
- advance = pending | next_page | auto_hit. The page moves at most one step per FS, regardless of how many sources are active.
- Because the shadow is captured in the same cycle as the select change, new-page data appear on the display one frame after the select change.
- next_page:
  - A pulse in any non-FS cycle sets pending and clears auto_cnt.
  - Repeated pulses within one frame saturate to a single step.
- Auto mode:
  - auto_hit = auto_en & (auto_cnt==AUTO_FRAMES-1) at FS.
  - At FS, auto_cnt <= 0 on hit or on advance; otherwise it increments.
  - auto_en=0 holds auto_cnt at 0.
- Output phases, registered with 1-cycle latency from (presc, idx):
  - If presc < BLANK_CYCLES: an_out=1111 and seg_out=8'hFF.
  - Otherwise: an_out = ~(1<<idx) and seg_out = shadow_(idx+1).
  - Exactly one or zero bits of an_out are low at any time, never more.
- No combinational path from any input to any output.
- Reset mid-slot or mid-frame: all state returns to reset values on that edge. Scanning restarts with FS on the first cycle after rst deasserts.

Test Plan:
(All with CLK_DIV=8, BLANK_CYCLES=2, AUTO_FRAMES=3.)
1. Reset: hold rst 3 cycles -> seg_out=FF, an_out=1111, select_out=00, frame_tick=0. Release -> frame_tick pulses 1 cycle later, then every 32 cycles.
2. Scan order: seg_in_1..4 = C0, F9, A4, B0. Each slot shows 2 cycles of 1111/FF, then 6 cycles of the digit pattern. Expected sequence: an_out=1110 with seg_out=C0, then 1101/F9, then 1011/A4, then 0111/B0, repeating. No cycle has two an_out bits low.
3. Snapshot: change seg_in_1 from C0 to 92 during slot 2 -> digit 1 still shows C0 for the rest of the frame and shows 92 from the next frame.
4. Paging: 3 next_page pulses within one frame -> select_out 00->01 exactly once, at the next FS. Four pulses in separate frames -> 01->10->11->00 (wraps). next_page asserted on the FS cycle itself -> advances at that FS.
5. Auto: auto_en=1 with no button -> select_out advances every 3 frames (96 cycles). A next_page pulse mid-count gives one advance at the next FS, and the following auto advance occurs 3 frames after that FS. auto_en=0 -> select_out stays stable.
6. Reset mid-operation: assert rst during slot 3 with select_out=10 -> next edge gives select_out=00, an_out=1111, seg_out=FF. After release, scanning restarts at digit 1.

Source files
------------

// File: rtl/seven_segment_scan_controller.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_controller
//
// Purpose:
//   Time-multiplexed scan and page controller for the 4-digit light-meter
//   display. Drives a shared active-low segment bus and four active-low digit
//   enables. A blanking gap at the start of every digit slot suppresses
//   ghosting. Also sequences the decoder's 2-bit page select. The page is
//   advanced by a next-page button pulse or by an auto-cycle frame timer.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous reset, active-high
//   seg_in_1    in   8  decoder pattern, rightmost digit (active-low, bit7=dp)
//   seg_in_2    in   8  decoder pattern, digit 2
//   seg_in_3    in   8  decoder pattern, digit 3
//   seg_in_4    in   8  decoder pattern, leftmost digit
//   next_page   in   1  one-cycle pulse from the debounced button
//   auto_en     in   1  level, enables auto page cycling
//   select_out  out  2  page select (00 ISO, 01 shutter, 10 focal, 11 bright)
//   seg_out     out  8  shared segment bus, active-low
//   an_out      out  4  digit enables, active-low, an_out[0] = digit 1
//   frame_tick  out  1  one-cycle pulse once per full 4-digit scan
// ---------------------------------------------------------------------------
module seven_segment_scan_controller #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int AUTO_FRAMES  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in_1,
  input  logic [7:0] seg_in_2,
  input  logic [7:0] seg_in_3,
  input  logic [7:0] seg_in_4,
  input  logic       next_page,
  input  logic       auto_en,
  output logic [1:0] select_out,
  output logic [7:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_FRAMES - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [1:0]    r_select;
  logic [7:0]    r_shadow [4];
  logic [7:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_frame_tick;
  logic          r_pending;
  logic [AW-1:0] r_auto_cnt;

  logic [7:0]    w_seg_in [4];
  logic          w_fs;
  logic          w_auto_hit;
  logic          w_advance;

  assign w_seg_in[0] = seg_in_1;
  assign w_seg_in[1] = seg_in_2;
  assign w_seg_in[2] = seg_in_3;
  assign w_seg_in[3] = seg_in_4;

  // Frame start: first cycle of digit slot 0, which is also the first cycle
  // after reset release because the counters reset to zero.
  assign w_fs       = (r_idx == 2'd0) && (r_presc == '0);
  assign w_auto_hit = auto_en && (r_auto_cnt == AUTO_LAST);
  // All sources OR together so the page moves by at most one step per frame.
  assign w_advance  = r_pending || next_page || w_auto_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_select     <= 2'd0;
      r_seg        <= 8'hFF;
      r_an         <= 4'b1111;
      r_frame_tick <= 1'b0;
      r_pending    <= 1'b0;
      r_auto_cnt   <= '0;
      for (int k = 0; k < 4; k++) begin
        r_shadow[k] <= 8'hFF;
      end
    end else begin
      // Slot prescaler and digit index.
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      r_frame_tick <= w_fs;

      // Page sequencing. The snapshot is taken in the same cycle the page
      // changes, so new-page data reach the display one frame later.
      if (w_fs) begin
        for (int k = 0; k < 4; k++) begin
          r_shadow[k] <= w_seg_in[k];
        end
        if (w_advance) begin
          r_select  <= r_select + 2'd1;
          r_pending <= 1'b0;
        end
      end else if (next_page) begin
        r_pending <= 1'b1;
      end

      // Auto-cycle frame counter; a button press restarts the count.
      if (!auto_en) begin
        r_auto_cnt <= '0;
      end else if (w_fs) begin
        r_auto_cnt <= w_advance ? '0 : r_auto_cnt + 1'b1;
      end else if (next_page) begin
        r_auto_cnt <= '0;
      end

      // Output phase, one cycle behind the counters. At most one enable low.
      if (r_presc < BLANK_END) begin
        r_an  <= 4'b1111;
        r_seg <= 8'hFF;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= r_shadow[r_idx];
      end
    end
  end

  assign select_out = r_select;
  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign frame_tick = r_frame_tick;

endmodule
